// File: rtl/fetch_unit_pkg.sv
// Shared widths, defaults and the fetch-queue entry type for the fetch stage.
package fetch_unit_pkg;

  localparam int INSTR_MEM_IDX_W = 8;
  localparam int INSTR_W         = 32;
  localparam int FQ_DEPTH_DEFAULT = 4;
  localparam logic [INSTR_MEM_IDX_W-1:0] RESET_PC_DEFAULT = '0;

  // One buffered fetch: the instruction, where it came from, and whether
  // the front end predicted it taken.
  typedef struct packed {
    logic [INSTR_W-1:0]         instr;
    logic [INSTR_MEM_IDX_W-1:0] pc;
    logic                       pred_taken;
  } fq_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// In-order FIFO of fetch entries between the PC stage and decode.
// Handshake: an entry moves out when the consumer sees !empty_o and raises
// pop_i in the same cycle; push_i must only be raised when a slot is free
// (not full, or a pop happens in the same cycle). flush_i wins over both.
module fetch_queue
  import fetch_unit_pkg::*;
#(
  parameter int DEPTH = FQ_DEPTH_DEFAULT
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           push_i,
  input  logic                           pop_i,
  input  logic                           flush_i,
  input  fq_entry_t                      wdata_i,
  output fq_entry_t                      rdata_o,
  output logic [$clog2(DEPTH+1)-1:0]     count_o,
  output logic                           full_o,
  output logic                           empty_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  fq_entry_t          mem_q [DEPTH];
  logic [PTR_W-1:0]   head_q, head_d;
  logic [PTR_W-1:0]   tail_q, tail_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               do_push, do_pop;

  // Flush overrides push and pop; pointers wrap naturally at DEPTH.
  always_comb begin
    do_push = push_i & ~flush_i;
    do_pop  = pop_i & ~flush_i & (count_q != '0);
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (flush_i) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (do_push) tail_d = tail_q + PTR_W'(1);
      if (do_pop)  head_d = head_q + PTR_W'(1);
      if (do_push && !do_pop)      count_d = count_q + CNT_W'(1);
      else if (do_pop && !do_push) count_d = count_q - CNT_W'(1);
    end
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Entry storage; contents are meaningless while the slot is not counted.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[tail_q] <= wdata_i;
  end

  assign count_o = count_q;
  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  // Empty queue presents zeros so decode never sees stale entries.
  assign rdata_o = empty_o ? '0 : mem_q[head_q];

endmodule

// File: rtl/fetch_unit.sv
// Fetch stage: owns the PC, picks the next PC from the BTB/predictor, and
// buffers fetched instructions for decode. Decode handshake: the head entry
// is taken when dec_valid & dec_ready; a redirect flushes and ignores it.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int                          FQ_DEPTH = FQ_DEPTH_DEFAULT,
  parameter logic [INSTR_MEM_IDX_W-1:0]  RESET_PC = RESET_PC_DEFAULT
) (
  input  logic                        clk,
  input  logic                        rst,
  output logic [INSTR_MEM_IDX_W-1:0]  fetch_pc,
  input  logic                        pred_taken,
  input  logic                        btb_hit,
  input  logic [INSTR_MEM_IDX_W-1:0]  btb_target,
  input  logic [INSTR_W-1:0]          imem_rdata,
  input  logic                        redirect_valid,
  input  logic [INSTR_MEM_IDX_W-1:0]  redirect_pc,
  output logic                        dec_valid,
  output logic [INSTR_W-1:0]          dec_instr,
  output logic [INSTR_MEM_IDX_W-1:0]  dec_pc,
  output logic                        dec_pred_taken,
  input  logic                        dec_ready
);

  localparam int CNT_W = $clog2(FQ_DEPTH+1);

  logic [INSTR_MEM_IDX_W-1:0] pc_q, pc_d;
  logic                       eff_taken;
  logic                       handshake;
  logic                       can_push;
  logic                       push, pop;
  fq_entry_t                  fq_wdata, fq_rdata;
  logic [CNT_W-1:0]           fq_count;
  logic                       fq_full, fq_empty;
  logic                       unused_count;

  // Next-PC selection with redirect taking priority over fetch and stall.
  always_comb begin
    // Without a BTB target a taken prediction cannot be followed.
    eff_taken = pred_taken & btb_hit;
    handshake = ~fq_empty & dec_ready;
    // A same-cycle pop frees the slot, so a full queue can still accept.
    can_push  = ~fq_full | handshake;
    push      = can_push & ~redirect_valid;
    pop       = handshake & ~redirect_valid;
    pc_d      = pc_q;
    if (redirect_valid)  pc_d = redirect_pc;
    else if (can_push)   pc_d = eff_taken ? btb_target : pc_q + INSTR_MEM_IDX_W'(1);
    fq_wdata.instr      = imem_rdata;
    fq_wdata.pc         = pc_q;
    fq_wdata.pred_taken = eff_taken;
  end

  // Program counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) pc_q <= RESET_PC;
    else     pc_q <= pc_d;
  end

  fetch_queue #(
    .DEPTH (FQ_DEPTH)
  ) u_fetch_queue (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .pop_i   (pop),
    .flush_i (redirect_valid),
    .wdata_i (fq_wdata),
    .rdata_o (fq_rdata),
    .count_o (fq_count),
    .full_o  (fq_full),
    .empty_o (fq_empty)
  );

  assign unused_count   = ^fq_count;
  assign fetch_pc       = pc_q;
  assign dec_valid      = ~fq_empty;
  assign dec_instr      = fq_rdata.instr;
  assign dec_pc         = fq_rdata.pc;
  assign dec_pred_taken = fq_rdata.pred_taken;

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Front-end fetch stage that owns the program counter.
- Drives fetch_pc to the branch predictor and the instruction memory, and combines pred_taken with a BTB hit/target to choose the next PC.
- Buffers fetched instructions in a small in-order fetch queue that feeds decode over a valid/ready handshake.
- Accepts redirects from branch resolution; a redirect flushes the queue and reloads the PC.

Parameters:
- FQ_DEPTH, 4, fetch queue entries (power of two, ≥2)
- RESET_PC, 0, PC value after reset (INSTR_MEM_IDX_W bits)

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- fetch_pc  out  INSTR_MEM_IDX_W  current PC; index to imem, bp and BTB
- pred_taken  in  1  direction prediction for fetch_pc (combinational, same cycle)
- btb_hit  in  1  BTB holds a target for fetch_pc (same cycle)
- btb_target  in  INSTR_MEM_IDX_W  predicted target for fetch_pc
- imem_rdata  in  INSTR_W  instruction at fetch_pc (combinational read)
- redirect_valid  in  1  mispredict/exception redirect from execute
- redirect_pc  in  INSTR_MEM_IDX_W  corrected PC
- dec_valid  out  1  queue head valid
- dec_instr  out  INSTR_W  head instruction
- dec_pc  out  INSTR_MEM_IDX_W  head PC
- dec_pred_taken  out  1  taken prediction recorded for the head
- dec_ready  in  1  decode accepts the head

Behaviour:
- Reset (async, rst=1):
  - pc=RESET_PC; queue count=0; head/tail pointers=0.
  - dec_valid=0; dec_instr, dec_pc, dec_pred_taken=0.
- fetch_pc = pc register, continuously.
- eff_taken = pred_taken & btb_hit. A taken prediction without a BTB hit has no target and is treated as not taken.
- pop = dec_valid & dec_ready.
- can_push = (count < FQ_DEPTH) | pop. A pop in the same cycle frees the slot, so a full queue that pops still accepts a push.
- Normal cycle (redirect_valid=0):
  - If can_push: write {imem_rdata, pc, eff_taken} at tail; tail++.
  - Next pc = eff_taken ? btb_target : pc+1. Increment wraps modulo 2^INSTR_MEM_IDX_W.
  - If !can_push: pc holds and nothing is written (fetch stall). fetch_pc stays stable, so the bp and imem re-read the same index.
- count update:
  - push & !pop: +1
  - pop & !push: −1
  - both or neither: unchanged
- Redirect cycle (redirect_valid=1) has top priority over push and pop:
  - pc <= redirect_pc; count <= 0; head <= tail <= 0.
  - No push and no pop occur. dec_valid is 0 from the next cycle.
  - dec_ready is ignored in this cycle, even if dec_valid was 1.
- Fetch from redirect_pc starts the cycle after the redirect. Redirect-to-first-push latency is 1 cycle.
- Outputs:
  - dec_valid = (count != 0), registered-state derived.
  - dec_instr, dec_pc, dec_pred_taken come from the head entry and hold stable while dec_valid & !dec_ready.
- Pointers are log2(FQ_DEPTH) bits and wrap naturally.
- Pipeline latency: an instruction fetched in cycle N is presented to decode at cycle N+1 at the earliest (empty queue).
- Throughput is one instruction per cycle while dec_ready=1.
- Back-to-back redirects: the last one wins, each one flushes.
- Reset mid-operation: immediate return to the reset state; queue contents are discarded.
- The unit does not generate bp updates; update_valid is driven from execute.

Decomposition:
- general_defines gains:
  - INSTR_W
  - FQ_DEPTH default
  - RESET_PC
  - typedef fq_entry_t {logic [INSTR_W-1:0] instr; logic [INSTR_MEM_IDX_W-1:0] pc; logic pred_taken;}
- One sub-module: fetch_queue.
  - Synchronous FIFO of fq_entry_t with push, pop and flush inputs; count, full and empty outputs.
  - fetch_unit holds the PC register, the next-PC mux and the redirect priority logic.

Test Plan:
- Reset, dec_ready=1, btb_hit=0 -> fetch_pc=0,1,2,3 on successive cycles; dec_pc=0,1,2 from cycle 1; dec_pred_taken=0.
- At pc=5: pred_taken=1, btb_hit=1, btb_target=20 -> next fetch_pc=20; entry pc=5 carries dec_pred_taken=1.
  - Same with btb_hit=0 -> next fetch_pc=6; dec_pred_taken=0.
- dec_ready=0 for 6 cycles from reset:
  - Queue fills with pc 0..3.
  - fetch_pc holds at 4 from cycle 4.
  - dec_pc stays 0.
  - Then dec_ready=1 -> dec_pc 0,1,2,3,4 with no gap; fetch resumes the same cycle.
- Queue full (4 entries), dec_ready=1 -> pop and push in the same cycle; count stays 4 and fetch_pc advances every cycle.
- Queue holding 3 entries, redirect_valid=1, redirect_pc=40, dec_ready=1 -> next cycle dec_valid=0, fetch_pc=40; following cycle dec_pc=40.
- Assert rst while queue is non-empty and pc=12 -> dec_valid=0 and fetch_pc=RESET_PC immediately, with no clock edge needed.
